// File: rtl/board_disp_pkg.sv
// Shared board display definitions: FSM state encoding, widths and the blank glyph.
package board_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } disp_state_e;

    localparam int HEX_W = 7;
    localparam int LED_W = 10;
    localparam int NIB_W = 4;

    localparam logic [HEX_W-1:0] HEX_BLANK = 7'h7F;

endpackage

// File: rtl/hex_display_arbiter_if.sv
// Requester/display bundle for hex_display_arbiter: requests and data in, grant and pin drive out.
interface hex_display_arbiter_if
    import board_disp_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*NIB_W-1:0] nibble_in;
    logic [N_REQ*LED_W-1:0] led_in;
    logic [N_REQ-1:0]       grant;
    logic [OW-1:0]          owner;
    logic                   busy;
    logic [HEX_W-1:0]       HEX;
    logic [LED_W-1:0]       LED;

    modport master (
        output req, nibble_in, led_in,
        input  grant, owner, busy, HEX, LED
    );

    modport slave (
        input  req, nibble_in, led_in,
        output grant, owner, busy, HEX, LED
    );

endinterface

// File: rtl/hex7seg.sv
// Combinational 4-bit to 7-segment decoder, active-low, bit0 = segment a .. bit6 = segment g.
module hex7seg
    import board_disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [HEX_W-1:0] seg
);

    always_comb begin
        seg = HEX_BLANK;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = HEX_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the single HEX digit and LED bank, with bounded dwell and a one-cycle gap.
// Define HEX_DISPLAY_HOLD_EN to keep the last owner's glyph/LEDs in IDLE/GAP instead of blanking.
module hex_display_arbiter
    import board_disp_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50
)(
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    hex_display_arbiter_if.slave  bus
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0]    S_IDLE    = IDLE;
    localparam logic [1:0]    S_SHOW    = SHOW;
    localparam logic [1:0]    S_GAP     = GAP;
    localparam logic [OW-1:0] OWNER_RST = OW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(HOLD_CYCLES);

    logic [1:0]                    state;
    logic [CW-1:0]                 cnt;
    logic [N_REQ-1:0]              grant_q;
    logic [OW-1:0]                 owner_q;
    logic [HEX_W-1:0]              hex_q;
    logic [LED_W-1:0]              led_q;
    logic [N_REQ-1:0][HEX_W-1:0]   seg_lane;
    logic [N_REQ-1:0][LED_W-1:0]   led_lane;
    logic [OW-1:0]                 pick;
    logic                          any_req;
    logic                          leave;

    assign led_lane = bus.led_in;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        hex7seg u_dec (
            .nibble (bus.nibble_in[i*NIB_W +: NIB_W]),
            .seg    (seg_lane[i])
        );
    end

    // Scan from last+N down to last+1 so the nearest requester after last wins.
    function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [OW-1:0]    last);
        logic [OW-1:0] sel;
        int            idx;
        sel = last;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % N_REQ;
            if (r[idx]) sel = OW'(idx);
        end
        return sel;
    endfunction

    assign any_req = |bus.req;
    assign pick    = rr_pick(bus.req, owner_q);
    assign leave   = !bus.req[owner_q] || (cnt == CNT_LAST);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            cnt     <= '0;
            grant_q <= '0;
            owner_q <= OWNER_RST;
        end else begin
            case (state)
                S_SHOW: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    if (leave) begin
                        state   <= S_GAP;
                        grant_q <= '0;
                    end
                end
                default: begin
                    if (any_req) begin
                        state   <= S_SHOW;
                        grant_q <= N_REQ'(1) << pick;
                        owner_q <= pick;
                        cnt     <= '0;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Display register samples the owner's lane while SHOW, so it trails grant by one cycle.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            hex_q <= HEX_BLANK;
            led_q <= '0;
        end else begin
`ifdef HEX_DISPLAY_HOLD_EN
            if (state == S_SHOW) begin
                hex_q <= seg_lane[owner_q];
                led_q <= led_lane[owner_q];
            end
`else
            if (state == S_SHOW) begin
                hex_q <= seg_lane[owner_q];
                led_q <= led_lane[owner_q];
            end else begin
                hex_q <= HEX_BLANK;
                led_q <= '0;
            end
`endif
        end
    end

    assign bus.grant = grant_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state == S_SHOW);
    assign bus.HEX   = hex_q;
    assign bus.LED   = led_q;

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Round-robin arbiter that shares the board's single 7-segment digit (HEX) and 10-LED bank between several requesters, such as switch-driven counters, key-event monitors and debug probes, in the Cyclone V board designs. Each granted requester owns the display for a fixed dwell time or until it drops its request. A one-cycle blank gap separates owners. The block drives the board-level HEX/LED pins directly and contains the hex-to-segment decode.

## Interface
- N_REQ, 4: number of requesters (2..8).
- HOLD_CYCLES, 50: maximum dwell per grant, in clock cycles (≥1).
- CLOCK_50  in  1  system clock; all logic is rising-edge.
- RESET_N  in  1  asynchronous, active-low reset.
- req  in  N_REQ  request, one bit per requester; level-sensitive.
- nibble_in  in  4*N_REQ  hex digit per requester; requester i occupies bits [4i+3:4i].
- led_in  in  10*N_REQ  LED pattern per requester; requester i occupies bits [10i+9:10i].
- grant  out  N_REQ  one-hot current owner; all-zero when no owner.
- owner  out  $clog2(N_REQ)  index of the current or last owner.
- busy  out  1  high while in SHOW.
- HEX  out  7  segment drive, active-low, bit0 = segment a … bit6 = segment g.
- LED  out  10  LED drive, active-high.

## Operation
- FSM states: IDLE, SHOW, GAP.
- IDLE:
  - If any req bit is set, select the next requester round-robin, starting at (last_owner+1) mod N_REQ.
  - Load grant and owner, clear the dwell counter, and go to SHOW.
  - Otherwise stay in IDLE.
- SHOW:
  - The dwell counter increments every cycle.
  - Go to GAP when req[owner]=0 is sampled, or when the counter reaches HOLD_CYCLES-1 (the HOLD_CYCLES-th grant cycle).
  - On leaving SHOW, last_owner ← owner and grant ← 0.
- GAP:
  - Lasts exactly one cycle, with grant=0.
  - The next state is chosen as in IDLE (SHOW with the next round-robin winner, else IDLE).
  - A lone persistent requester is re-granted after every gap.
- Requests from non-owners never preempt the owner.
- Dwell counter width is $clog2(HOLD_CYCLES+1). The counter saturates and never wraps.
- Decode covers 0–F in standard DE-board glyphs. The blank pattern is HEX=7'h7F.
- Reset values:
  - State: IDLE.
  - grant=0, busy=0, owner=N_REQ-1 (last_owner=N_REQ-1, so requester 0 wins first).
  - HEX=7'h7F, LED=0, dwell counter=0.
- When RESET_N is asserted mid-SHOW, all outputs take their reset values immediately (asynchronously). Arbitration restarts from requester 0.

## Timing
- Request to grant latency: req sampled high in IDLE/GAP at edge k gives grant high after edge k.
- Display pipeline: HEX and LED are registered. The value after edge k+1 is decode(nibble_in[owner]) and led_in[owner] as sampled at edge k+1 while SHOW. So the display lags grant by one cycle and stays valid one cycle after grant falls.
- Otherwise (IDLE/GAP sampled): HEX and LED show the blank/off value (see Configuration).
- With req held continuously, grant is high for exactly HOLD_CYCLES cycles, followed by a 1-cycle gap.
- Early drop: if req[owner] is low at edge k, grant falls after edge k.
- Simultaneous expiry and drop: treated identically to either event alone (single gap cycle).
- owner holds its value through GAP and IDLE.

## Configuration
- HEX_DISPLAY_HOLD_EN:
  - Defined: in IDLE and GAP, HEX and LED retain the last displayed owner's values instead of blanking. Reset still blanks them.
  - Undefined (default): in IDLE and GAP, HEX=7'h7F and LED=0.

## Structure
- Shared package board_disp_pkg holds:
  - State enum {IDLE, SHOW, GAP}.
  - HEX_BLANK=7'h7F constant.
  - Width constants HEX_W=7, LED_W=10, NIB_W=4.
- Sub-module hex7seg: purely combinational 4-bit to 7-segment active-low decoder, reused by other board tops.
- Round-robin pick is a function inside the arbiter; it is not a separate module.

## Test plan
- Reset: hold RESET_N=0 with req=4'b1111 → grant=0, HEX=7'h7F, LED=0, owner=3. Release → grant=4'b0001 after the first edge.
- Rotation (HOLD_CYCLES=4): req=4'b1111 held → grants 0001,0010,0100,1000,0001. Each lasts 4 cycles, separated by 1-cycle gaps with grant=0.
- Early drop: requester 2 alone with nibble=4'hA. Drop req[2] on the 2nd grant cycle → grant falls next edge. HEX=7'b0001000 ("A") for one cycle after grant, then 7'h7F in the undefined-macro build.
- Lone requester: req=4'b0100 held → grant=0100 for HOLD_CYCLES, gap, then 0100 again. owner stays 2.
- Data path: owner 1 with nibble 4'h3 and led 10'h2AA → HEX=7'b0110000, LED=10'h2AA one cycle after grant. Change nibble to 4'h0 mid-dwell → HEX=7'b1000000 next cycle.
- Mid-dwell reset: assert RESET_N=0 asynchronously during SHOW → outputs reset before the next clock edge. Release → requester 0 is granted first.
